// File: rtl/idma_desc64_ar_prefetcher.sv
// AR-channel prefetcher for 64-bit descriptor chains: speculatively fetches contiguous
// descriptors and reports how many wrongly fetched ones the R-channel gater must discard.
module idma_desc64_ar_prefetcher #(
    parameter int unsigned NSpeculation = 4,
    parameter type         flush_t      = logic [$clog2(NSpeculation + 1)-1:0],
    parameter int unsigned DescBytes    = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [63:0] desc_addr_i,
    input  logic        desc_addr_valid_i,
    output logic        desc_addr_ready_o,
    input  logic [63:0] next_addr_i,
    input  logic        next_addr_valid_i,
    output logic [63:0] ar_addr_o,
    output logic        ar_valid_o,
    input  logic        ar_ready_i,
    output flush_t      n_to_flush_o,
    output logic        n_to_flush_valid_o,
    output logic        busy_o
);

    localparam int unsigned CntW       = $clog2(NSpeculation + 1);
    localparam logic [63:0] EndOfChain = '1;
    localparam logic [63:0] Stride     = 64'(DescBytes);

    typedef enum logic {IDLE, FETCH} state_e;

    state_e          state;
    logic [CntW-1:0] inflight;
    logic [63:0]     issue_addr;
    logic [63:0]     head_addr;
    logic [63:0]     predicted;
    logic            ar_hs;
    logic            can_load;
    logic            is_end;
    logic            is_hit;

    assign ar_hs             = ar_valid_o & ar_ready_i;
    assign can_load          = (!ar_valid_o || ar_ready_i) && (inflight < CntW'(NSpeculation))
                               && !next_addr_valid_i;
    assign predicted         = head_addr + Stride;
    assign is_end            = (next_addr_i == EndOfChain);
    assign is_hit            = (inflight > CntW'(1)) && (next_addr_i == predicted);
    assign desc_addr_ready_o = (state == IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= IDLE;
            inflight           <= '0;
            issue_addr         <= '0;
            head_addr          <= '0;
            ar_addr_o          <= '0;
            ar_valid_o         <= 1'b0;
            n_to_flush_o       <= '0;
            n_to_flush_valid_o <= 1'b0;
            busy_o             <= 1'b0;
        end else begin
            n_to_flush_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    // A request left over from an ended chain still has to finish its handshake.
                    if (ar_hs) ar_valid_o <= 1'b0;
                    if (desc_addr_valid_i) begin
                        issue_addr <= desc_addr_i;
                        inflight   <= '0;
                        state      <= FETCH;
                        busy_o     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (next_addr_valid_i) begin
                        if (ar_hs) ar_valid_o <= 1'b0;
                        if (inflight != '0) begin
                            n_to_flush_valid_o <= 1'b1;
                            if (is_end) begin
                                n_to_flush_o <= flush_t'(inflight - CntW'(1));
                                inflight     <= '0;
                                state        <= IDLE;
                                busy_o       <= 1'b0;
                            end else if (is_hit) begin
                                n_to_flush_o <= '0;
                                inflight     <= inflight - CntW'(1);
                                head_addr    <= predicted;
                            end else begin
                                // With a single descriptor in flight this yields zero: nothing speculative to drop.
                                n_to_flush_o <= flush_t'(inflight - CntW'(1));
                                issue_addr   <= next_addr_i;
                                inflight     <= '0;
                            end
                        end
                    end else if (can_load) begin
                        ar_addr_o  <= issue_addr;
                        ar_valid_o <= 1'b1;
                        issue_addr <= issue_addr + Stride;
                        inflight   <= inflight + CntW'(1);
                        if (inflight == '0) head_addr <= issue_addr;
                    end else if (ar_hs) begin
                        ar_valid_o <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    decode_in_flight_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        next_addr_valid_i |-> (state == FETCH && inflight != '0));
`endif

endmodule
